// File: rtl/unified_mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package unified_mem_arb_pkg;

  localparam int STARVE_CNT_W = 3;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/unified_mem_arb_pick.sv
// Priority pick between fetch and data requesters, with a starvation counter
// that forces the fetch side to win after STARVE_MAX consecutive data wins.
module unified_mem_arb_pick
  import unified_mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic       w_clock,
  input  logic       w_reset,
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       arb_go,
  output arb_owner_t owner
);

  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    starved;

  assign starved = (starve_cnt == STARVE_CNT_W'(STARVE_MAX));

  always_comb begin
    owner = OWN_IF;
    if (dm_req && !(if_req && starved)) begin
      owner = OWN_DM;
    end
  end

  // Only data wins over a waiting fetch count; any fetch win clears.
  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      starve_cnt <= '0;
    end else if (arb_go) begin
      if (owner == OWN_IF) begin
        starve_cnt <= '0;
      end else if (if_req && !starved) begin
        starve_cnt <= starve_cnt + STARVE_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported unified memory between the fetch port and the
// load/store port; one transaction outstanding, data side has priority.
module unified_mem_arbiter
  import unified_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              w_clock,
  input  logic              w_reset,
  input  logic              w_if_req,
  input  logic [ADDR_W-1:0] w_if_addr,
  output logic [DATA_W-1:0] w_if_rdata,
  output logic              w_if_valid,
  output logic              w_if_stall,
  input  logic              w_dm_req,
  input  logic              w_dm_write,
  input  logic [ADDR_W-1:0] w_dm_addr,
  input  logic [DATA_W-1:0] w_dm_wdata,
  input  logic [3:0]        w_dm_be,
  output logic [DATA_W-1:0] w_dm_rdata,
  output logic              w_dm_valid,
  output logic              w_dm_stall,
  output logic              w_mem_req,
  output logic              w_mem_write,
  output logic [ADDR_W-1:0] w_mem_addr,
  output logic [DATA_W-1:0] w_mem_wdata,
  output logic [3:0]        w_mem_be,
  input  logic              w_mem_gnt,
  input  logic              w_mem_rvalid,
  input  logic [DATA_W-1:0] w_mem_rdata
);

  // state     | meaning
  // ARB_IDLE  | arbitrate between pending requests
  // ARB_ISSUE | request presented to memory, waiting for gnt
  // ARB_WAIT  | granted, waiting for rvalid
  // ARB_DONE  | owner's valid pulse, no arbitration

  arb_state_t state;
  arb_state_t state_nxt;
  arb_owner_t owner;
  arb_owner_t pick_owner;
  logic       arb_go;

  unified_mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .w_clock(w_clock),
    .w_reset(w_reset),
    .if_req (w_if_req),
    .dm_req (w_dm_req),
    .arb_go (arb_go),
    .owner  (pick_owner)
  );

  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    arb_go    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (w_if_req || w_dm_req) begin
          arb_go    = 1'b1;
          state_nxt = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (w_mem_gnt) begin
          state_nxt = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (w_mem_rvalid) begin
          state_nxt = ARB_DONE;
        end
      end
      ARB_DONE: begin
        state_nxt = ARB_IDLE;
      end
      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Request fields are latched once at arbitration so requester-side changes
  // during the transaction cannot disturb the access in flight.
  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      owner       <= OWN_IF;
      w_mem_req   <= 1'b0;
      w_mem_write <= 1'b0;
      w_mem_addr  <= '0;
      w_mem_wdata <= '0;
      w_mem_be    <= 4'h0;
      w_if_rdata  <= '0;
      w_dm_rdata  <= '0;
      w_if_valid  <= 1'b0;
      w_dm_valid  <= 1'b0;
    end else begin
      w_if_valid <= 1'b0;
      w_dm_valid <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (arb_go) begin
            owner     <= pick_owner;
            w_mem_req <= 1'b1;
            if (pick_owner == OWN_DM) begin
              w_mem_write <= w_dm_write;
              w_mem_addr  <= w_dm_addr;
              w_mem_wdata <= w_dm_wdata;
              w_mem_be    <= w_dm_be;
            end else begin
              w_mem_write <= 1'b0;
              w_mem_addr  <= w_if_addr;
              w_mem_wdata <= '0;
              w_mem_be    <= 4'hF;
            end
          end
        end
        ARB_ISSUE: begin
          if (w_mem_gnt) begin
            w_mem_req <= 1'b0;
          end
        end
        ARB_WAIT: begin
          if (w_mem_rvalid) begin
            if (owner == OWN_DM) begin
              w_dm_rdata <= w_mem_rdata;
              w_dm_valid <= 1'b1;
            end else begin
              w_if_rdata <= w_mem_rdata;
              w_if_valid <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign w_if_stall = w_if_req & ~w_if_valid;
  assign w_dm_stall = w_dm_req & ~w_dm_valid;

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

- Shares one single-ported unified instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port of the 5-stage MIPS pipeline.
- Owns arbitration, the memory request/grant/response handshake and per-requester stall outputs, which feed the pipeline stall logic alongside the load-use hazard stall.
- One transaction is outstanding at a time. Data accesses have priority, and a starvation counter bounds fetch delay.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 3, consecutive data wins over a pending fetch before fetch is forced to win (1..7)

Ports:
- w_clock  in  1  single clock; all state changes on rising edge
- w_reset  in  1  synchronous, active-high reset
- w_if_req  in  1  fetch request; held until w_if_valid
- w_if_addr  in  ADDR_W  fetch address
- w_if_rdata  out  DATA_W  fetched word; valid while w_if_valid=1
- w_if_valid  out  1  one-cycle completion pulse
- w_if_stall  out  1  w_if_req & ~w_if_valid
- w_dm_req  in  1  data request; held until w_dm_valid
- w_dm_write  in  1  1=store, 0=load
- w_dm_addr  in  ADDR_W  data address
- w_dm_wdata  in  DATA_W  store data
- w_dm_be  in  4  store byte enables
- w_dm_rdata  out  DATA_W  load word; valid while w_dm_valid=1
- w_dm_valid  out  1  one-cycle completion pulse (loads and stores)
- w_dm_stall  out  1  w_dm_req & ~w_dm_valid
- w_mem_req  out  1  memory request, registered
- w_mem_write, w_mem_addr, w_mem_wdata, w_mem_be  out  1/ADDR_W/DATA_W/4  registered request fields; w_mem_write=0 and w_mem_be=4'hF for fetch
- w_mem_gnt  in  1  memory accepts request
- w_mem_rvalid  in  1  response (read data or write ack)
- w_mem_rdata  in  DATA_W  read data

## Operation
State machine:
- IDLE: arbitrate.
  - Only w_dm_req set → owner=DM.
  - Only w_if_req set → owner=IF.
  - Both set → owner=DM unless starve_cnt==STARVE_MAX, then owner=IF.
  - Latch the winner's fields into the w_mem_* registers, set w_mem_req=1 and go to ISSUE.
  - No request → stay in IDLE.
- ISSUE: hold w_mem_req and all fields stable. On w_mem_gnt, clear w_mem_req and go to WAIT. w_mem_rvalid is ignored here.
- WAIT: on w_mem_rvalid, capture w_mem_rdata into the owner's rdata register and go to DONE.
- DONE: assert the owner's valid for exactly one cycle, then go to IDLE. No arbitration occurs in DONE.

Starvation counter (starve_cnt, 3 bits):
- Increments when DM wins while w_if_req=1.
- Clears when IF wins.
- Saturates at STARVE_MAX.

Other rules:
- Non-owner rdata registers hold their previous value.
- w_dm_rdata is don't-care for stores.
- rvalid arriving in IDLE, ISSUE or DONE is dropped.
- Requests are sampled only in IDLE. A requester changing its fields mid-transaction does not alter the in-flight access.

## Timing
- Reset values: state=IDLE, starve_cnt=0, w_mem_req=0, w_mem_write=0, w_mem_addr=0, w_mem_wdata=0, w_mem_be=0, both valids=0, both rdata=0.
- Both stall outputs follow their equations during reset (combinational from req).
- Minimum latency, request in cycle 0:
  - w_mem_req=1 in cycle 1.
  - gnt in cycle 1, rvalid in cycle 2.
  - valid in cycle 3.
  - Earliest next issue is cycle 5, since IDLE in cycle 4 samples the requester's next request.
- Each extra cycle of gnt or rvalid delay adds one cycle.
- The memory must not assert rvalid in the same cycle as gnt. Such an rvalid is dropped.
- Reset mid-transaction: the next cycle is IDLE with all outputs at reset values. A late rvalid from the aborted access is dropped.
- Simultaneous req assertion by both requesters in IDLE is resolved by the priority rule above, within the same cycle.

## Structure
- Package unified_mem_arb_pkg holds:
  - state enum ARB_IDLE/ARB_ISSUE/ARB_WAIT/ARB_DONE;
  - owner enum OWN_IF/OWN_DM;
  - STARVE_CNT_W=3.
- Sub-module unified_mem_arb_pick holds the combinational priority pick plus the starve_cnt register. It takes both reqs and an arbitrate strobe and returns the owner.
- The FSM, request registers and response capture stay in the top module.

## Test plan
- Fetch only:
  - Stimulus: w_if_req=1, addr=0x0040_0000; gnt in cycle 1, rvalid in cycle 2 with rdata=0x2408_0005.
  - Response: w_if_valid=1 with rdata 0x2408_0005 in cycle 3; w_if_stall=1 in cycles 0–2 and 0 in cycle 3.
- Collision:
  - Stimulus: both reqs set in cycle 0; DM is a store, addr=0x1001_0000, wdata=0xDEAD_BEEF, be=4'b0011.
  - Response: w_mem_write=1 and w_mem_be=4'b0011 in cycle 1; w_dm_valid precedes w_if_valid; the fetch issues on the next IDLE.
- Starvation:
  - Stimulus: w_if_req held at 1 while DM issues back-to-back loads, with STARVE_MAX=3.
  - Response: after 3 DM transactions, IF wins the 4th arbitration and starve_cnt returns to 0.
- Delayed handshake:
  - Stimulus: gnt delayed 2 cycles and rvalid delayed 3 cycles after gnt.
  - Response: w_mem_* fields stay stable throughout ISSUE; valid arrives 1 cycle after rvalid.
- Reset in WAIT:
  - Stimulus: w_reset=1 for one cycle during WAIT, then rvalid arrives.
  - Response: no valid pulse; all outputs at reset values; a fresh request then completes normally.
- Early rvalid:
  - Stimulus: rvalid asserted in the same cycle as gnt.
  - Response: rvalid ignored; the transaction completes only on a later rvalid.
